// File: rtl/dp_mem.sv
`default_nettype none
// ============================================================================
// Module   : dp_mem
// Brief    : Simple dual-port synchronous RAM with one write port, one read
//            port, global enable and registered read data.
// Revision : 1.0 - initial release
// ============================================================================

module dp_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [DATA_WIDTH-1:0] r_data_d;

  // Read samples mem_q, so a same-address write lands after the old word is taken.
  always_comb begin
    mem_d    = mem_q;
    r_data_d = r_data_q;
    if (enb) begin
      if (rd) begin
        r_data_d = mem_q[r_addr];
      end
      if (wr) begin
        mem_d[w_addr] = w_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      r_data_q <= '0;
    end else begin
      mem_q    <= mem_d;
      r_data_q <= r_data_d;
    end
  end

  assign r_data = r_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dp_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_mem
// Brief    : Scoreboard bench for dp_mem: directed scenarios plus random traffic
//            against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_dp_mem;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          enb;
  logic          wr;
  logic          rd;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_rdata;
  logic [DW-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  dp_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .enb    (enb),
    .wr     (wr),
    .rd     (rd),
    .w_addr (w_addr),
    .r_addr (r_addr),
    .w_data (w_data),
    .r_data (r_data)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_rdata = '0;
  endtask

  // Apply one cycle of stimulus; the model takes the edge and queues the
  // r_data value expected after it.
  task automatic drive(input logic e, input logic w, input logic r,
                       input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                       input logic [DW-1:0] wd);
    enb = e; wr = w; rd = r; w_addr = wa; r_addr = ra; w_data = wd;
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else if (e) begin
      if (r) ref_rdata = ref_mem[ra];
      if (w) ref_mem[wa] = wd;
    end
    exp_q.push_back(ref_rdata);
    #1;
  endtask

  task automatic check_now(input string name, input logic [DW-1:0] exp);
    checks++;
    if (r_data !== exp) begin
      errors++;
      $display("FAIL %s: r_data=%h expected=%h at %0t", name, r_data, exp, $time);
    end
  endtask

  // Drop reset between edges, after any pending scoreboard entry is retired.
  task automatic async_reset(input string name);
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    check_now(name, '0);
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b1, 1'b1, 1'b0, a, '0, d);
  endtask

  task automatic read(input logic [AW-1:0] a);
    drive(1'b1, 1'b0, 1'b1, '0, a, '0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Monitor: every edge produces a defined r_data, checked half a cycle later.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (r_data !== e) begin
          errors++;
          $display("FAIL scoreboard: r_data=%h expected=%h at %0t", r_data, e, $time);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; enb = 1'b0; wr = 1'b0; rd = 1'b0;
    w_addr = '0; r_addr = '0; w_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset after arbitrary writes, held two cycles with requests ignored.
    write(4'd0, 8'h12); write(4'd5, 8'h34); write(4'd15, 8'h56);
    read(4'd5);
    async_reset("reset_entry");
    drive(1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 8'hEE);
    drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 8'hDD);
    rst = 1'b1;
    read(4'd0); read(4'd5); read(4'd15);

    // Basic write then read, then hold.
    write(4'd3, 8'hA5);
    read(4'd3);
    idle(); drive(1'b1, 1'b0, 1'b0, '0, 4'd3, '0);

    // Enable gating on both ports.
    drive(1'b0, 1'b1, 1'b0, 4'd7, '0, 8'h3C);
    read(4'd7);
    read(4'd3);
    drive(1'b0, 1'b0, 1'b1, '0, 4'd7, '0);

    // Same-address collision returns the old word.
    write(4'd9, 8'h11);
    drive(1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 8'h22);
    read(4'd9);

    // Independent ports in one cycle.
    write(4'd15, 8'h0F);
    drive(1'b1, 1'b1, 1'b1, 4'd0, 4'd15, 8'hFF);
    read(4'd0);

    // Last write wins.
    write(4'd4, 8'h01); write(4'd4, 8'h02); read(4'd4);

    // Reset between edges while r_data is non-zero.
    write(4'd2, 8'h55);
    read(4'd2);
    async_reset("reset_midop");
    idle();
    rst = 1'b1;
    read(4'd2);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
            DW'($urandom));
    end

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
